// File: rtl/ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ctrl_pkg
//  Description : Shared types and encodings for the multicycle control path:
//                sequencer state enum, datapath mux encodings, ALU operation
//                and instruction Op-field encodings.
//  Revision    : 1.0  initial release
// ============================================================================
package ctrl_pkg;

    // Sequencer states, one per instruction step
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9
    } state_t;

    // ALU B operand select
    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // Result bus select
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    // ALU operation
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    // Instruction class, bits [27:26]
    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;
    localparam logic [1:0] OP_ILL = 2'b11;

endpackage : ctrl_pkg
`default_nettype wire

// File: rtl/alu_dec.sv
`default_nettype none
// ============================================================================
//  Module      : alu_dec
//  Description : Combinational ALU decoder. Maps the data-processing cmd field
//                to an ALU operation and the S bit to flag-write requests.
//                When alu_op is low the ALU performs ADD and no flags are
//                requested.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_dec
    import ctrl_pkg::*;
(
    input  logic       alu_op,
    input  logic [5:0] funct,
    output logic [1:0] alu_control,
    output logic [1:0] flag_w
);

    logic [3:0] cmd;
    logic       s_bit;

    assign cmd   = funct[4:1];
    assign s_bit = funct[0];

    // Decode cmd to an ALU op; NZ follows S, CV only for arithmetic ops
    always_comb begin
        alu_control = ALU_ADD;
        flag_w      = 2'b00;
        if (alu_op) begin
            case (cmd)
                4'b0100: alu_control = ALU_ADD;
                4'b0010: alu_control = ALU_SUB;
                4'b0000: alu_control = ALU_AND;
                4'b1100: alu_control = ALU_ORR;
                default: alu_control = ALU_ADD;
            endcase
            flag_w[1] = s_bit;
            flag_w[0] = s_bit & ((alu_control == ALU_ADD) | (alu_control == ALU_SUB));
        end
    end

endmodule : alu_dec
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_ctrl
//  Description : Main control sequencer for the multicycle ARM-subset core.
//                Steps each instruction through fetch/decode/execute/memory/
//                writeback and drives datapath selects and enables as Moore
//                decodes of the state. Memory states wait on MemReady.
//  Revision    : 1.0  initial release
// ============================================================================
module multicycle_ctrl
    import ctrl_pkg::*;
(
    input  logic       CLK,
    input  logic       RESETn,
    input  logic       MemReady,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    output logic       IRWrite,
    output logic       NextPC,
    output logic       AdrSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUControl,
    output logic [1:0] FlagW,
    output logic       PCS,
    output logic       RegW,
    output logic       MemW,
    output logic       InstrDone,
    output logic       Illegal
);

    state_t state;
    state_t state_next;
    logic   alu_op;
    logic   rd_is_pc;

    assign rd_is_pc = (Rd == 4'd15);

    alu_dec u_alu_dec (
        .alu_op      (alu_op),
        .funct       (Funct),
        .alu_control (ALUControl),
        .flag_w      (FlagW)
    );

    // State register; reset returns to FETCH immediately
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state <= S_FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and Moore output decode
    always_comb begin
        state_next = state;
        IRWrite    = 1'b0;
        NextPC     = 1'b0;
        AdrSrc     = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = SRCB_REG;
        ResultSrc  = RES_ALUOUT;
        PCS        = 1'b0;
        RegW       = 1'b0;
        MemW       = 1'b0;
        InstrDone  = 1'b0;
        Illegal    = 1'b0;
        alu_op     = 1'b0;
        case (state)
            S_FETCH: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALU;
                // Reset holds the state in FETCH, so the load enables must
                // also see RESETn to stay quiet while reset is asserted
                IRWrite   = MemReady & RESETn;
                NextPC    = MemReady & RESETn;
                if (MemReady) state_next = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALU;
                case (Op)
                    OP_DP:   state_next = Funct[5] ? S_EXECI : S_EXECR;
                    OP_MEM:  state_next = S_MEMADR;
                    OP_BR:   state_next = S_BRANCH;
                    default: begin
                        Illegal    = 1'b1;
                        InstrDone  = 1'b1;
                        state_next = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcB    = SRCB_IMM;
                state_next = Funct[0] ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
                if (MemReady) state_next = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc  = RES_DATA;
                RegW       = 1'b1;
                PCS        = rd_is_pc;
                InstrDone  = 1'b1;
                state_next = S_FETCH;
            end
            S_MEMWRITE: begin
                AdrSrc = 1'b1;
                MemW   = 1'b1;
                if (MemReady) begin
                    InstrDone  = 1'b1;
                    state_next = S_FETCH;
                end
            end
            S_EXECR: begin
                ALUSrcB    = SRCB_REG;
                alu_op     = 1'b1;
                state_next = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcB    = SRCB_IMM;
                alu_op     = 1'b1;
                state_next = S_ALUWB;
            end
            S_ALUWB: begin
                ResultSrc  = RES_ALUOUT;
                RegW       = 1'b1;
                PCS        = rd_is_pc;
                InstrDone  = 1'b1;
                state_next = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcB    = SRCB_IMM;
                ResultSrc  = RES_ALU;
                PCS        = 1'b1;
                InstrDone  = 1'b1;
                state_next = S_FETCH;
            end
            default: state_next = S_FETCH;
        endcase
    end

endmodule : multicycle_ctrl
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multicycle_ctrl
//  Description : Self-checking bench for multicycle_ctrl. An instruction-level
//                model expands each instruction into its expected per-cycle
//                output vectors; every cycle is compared, and a few literal
//                expectations pin specific cycles of specific instructions.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_multicycle_ctrl;

    typedef struct packed {
        logic       irw;
        logic       npc;
        logic       adr;
        logic       asa;
        logic [1:0] asb;
        logic [1:0] rs;
        logic [1:0] alc;
        logic [1:0] fw;
        logic       pcs;
        logic       regw;
        logic       memw;
        logic       done;
        logic       ill;
    } outs_t;

    logic       CLK;
    logic       RESETn;
    logic       MemReady;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] Rd;
    logic       IRWrite, NextPC, AdrSrc, ALUSrcA;
    logic [1:0] ALUSrcB, ResultSrc, ALUControl, FlagW;
    logic       PCS, RegW, MemW, InstrDone, Illegal;

    int checks   = 0;
    int failures = 0;

    outs_t exp_q[$];
    bit    mr_q[$];
    outs_t trace[0:31];
    int    trace_n;

    multicycle_ctrl dut (
        .CLK        (CLK),
        .RESETn     (RESETn),
        .MemReady   (MemReady),
        .Op         (Op),
        .Funct      (Funct),
        .Rd         (Rd),
        .IRWrite    (IRWrite),
        .NextPC     (NextPC),
        .AdrSrc     (AdrSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ResultSrc  (ResultSrc),
        .ALUControl (ALUControl),
        .FlagW      (FlagW),
        .PCS        (PCS),
        .RegW       (RegW),
        .MemW       (MemW),
        .InstrDone  (InstrDone),
        .Illegal    (Illegal)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic outs_t dut_outs();
        outs_t o;
        o.irw  = IRWrite;   o.npc = NextPC;    o.adr  = AdrSrc;  o.asa  = ALUSrcA;
        o.asb  = ALUSrcB;   o.rs  = ResultSrc; o.alc  = ALUControl; o.fw = FlagW;
        o.pcs  = PCS;       o.regw = RegW;     o.memw = MemW;    o.done = InstrDone;
        o.ill  = Illegal;
        return o;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    // ---------------- instruction-level model ----------------
    function automatic outs_t pc_step(bit rdy);
        outs_t o = '0;
        o.asa = 1'b1; o.asb = 2'b10; o.rs = 2'b10;
        o.irw = rdy;  o.npc = rdy;
        return o;
    endfunction

    function automatic logic [3:0] alu_ref(logic [3:0] cmd, logic s);
        logic [1:0] op;
        case (cmd)
            4'b0100: op = 2'b00;
            4'b0010: op = 2'b01;
            4'b0000: op = 2'b10;
            4'b1100: op = 2'b11;
            default: op = 2'b00;
        endcase
        return {op, s, s & (op == 2'b00 || op == 2'b01)};
    endfunction

    task automatic push(input outs_t o, input bit mr);
        exp_q.push_back(o);
        mr_q.push_back(mr);
    endtask

    task automatic build(input logic [1:0] op, input logic [5:0] f, input logic [3:0] rd,
                         input int fwait, input int mwait);
        outs_t o;
        exp_q.delete();
        mr_q.delete();
        for (int i = 0; i < fwait; i++) push(pc_step(1'b0), 1'b0);
        push(pc_step(1'b1), 1'b1);
        o = pc_step(1'b0);
        if (op == 2'b11) begin o.ill = 1'b1; o.done = 1'b1; end
        push(o, 1'($urandom_range(0, 1)));
        if (op == 2'b00) begin
            o = '0;
            o.asb = f[5] ? 2'b01 : 2'b00;
            {o.alc, o.fw} = alu_ref(f[4:1], f[0]);
            push(o, 1'($urandom_range(0, 1)));
            o = '0; o.regw = 1'b1; o.pcs = (rd == 4'd15); o.done = 1'b1;
            push(o, 1'($urandom_range(0, 1)));
        end else if (op == 2'b01) begin
            o = '0; o.asb = 2'b01;
            push(o, 1'($urandom_range(0, 1)));
            o = '0; o.adr = 1'b1; o.memw = !f[0];
            for (int i = 0; i < mwait; i++) push(o, 1'b0);
            if (!f[0]) o.done = 1'b1;
            push(o, 1'b1);
            if (f[0]) begin
                o = '0; o.rs = 2'b01; o.regw = 1'b1; o.pcs = (rd == 4'd15); o.done = 1'b1;
                push(o, 1'($urandom_range(0, 1)));
            end
        end else if (op == 2'b10) begin
            o = '0; o.asb = 2'b01; o.rs = 2'b10; o.pcs = 1'b1; o.done = 1'b1;
            push(o, 1'($urandom_range(0, 1)));
        end
    endtask

    // Entered at posedge+1 with the DUT in FETCH; leaves at posedge+1 of the
    // cycle after the instruction (or mid-cycle at abort_at).
    task automatic run(input string name, input logic [1:0] op, input logic [5:0] f,
                       input logic [3:0] rd, input int fwait, input int mwait,
                       input int lat, input int abort_at);
        int first_done;
        outs_t got;
        build(op, f, rd, fwait, mwait);
        Op = op; Funct = f; Rd = rd;
        first_done = -1;
        trace_n = 0;
        for (int i = 0; i < exp_q.size(); i++) begin
            MemReady = mr_q[i];
            #1;
            got = dut_outs();
            trace[i] = got;
            trace_n++;
            checks++;
            if (got !== exp_q[i]) begin
                failures++;
                $display("FAIL %s cyc%0d got=%h want=%h", name, i, got, exp_q[i]);
            end
            if (got.done && first_done < 0) first_done = i;
            if (i == abort_at) return;
            @(posedge CLK);
            #1;
        end
        chk({name, "_latency"}, first_done + 1, lat);
    endtask

    initial begin
        int memw_n, done_n, bad_n;
        RESETn = 1'b0; MemReady = 1'b1; Op = 2'b00; Funct = 6'd0; Rd = 4'd0;
        repeat (2) @(posedge CLK);
        #2;
        chk("reset_outs", dut_outs(), pc_step(1'b0));
        @(negedge CLK);
        MemReady = 1'b0;
        RESETn   = 1'b1;
        @(posedge CLK); #1;

        // ADD R1,R2,R3 with S
        run("add_s", 2'b00, 6'b001001, 4'd1, 0, 0, 4, -1);
        chk("add_fw_decode", trace[1].fw, 2'b00);
        chk("add_fw_exec", trace[2].fw, 2'b11);
        chk("add_fw_wb", trace[3].fw, 2'b00);
        chk("add_wb_regw_done_pcs", {trace[3].regw, trace[3].done, trace[3].pcs}, 3'b110);

        // More DP patterns, including fetch wait and Rd=15
        run("subi_s",  2'b00, 6'b100101, 4'd2,  0, 0, 4, -1);
        chk("subi_alc", trace[2].alc, 2'b01);
        run("and_ns",  2'b00, 6'b000000, 4'd3,  2, 0, 6, -1);
        run("orr_s",   2'b00, 6'b011001, 4'd15, 0, 0, 4, -1);
        chk("orr_fw", {trace[2].alc, trace[2].fw}, 4'b1110);
        run("dflt_s",  2'b00, 6'b110101, 4'd4,  1, 0, 5, -1);

        // LDR R15,[R0,#4] with two wait cycles in MEMREAD
        run("ldr_pc", 2'b01, 6'b011001, 4'd15, 0, 2, 7, -1);
        chk("ldr_memwb", {trace[6].rs, trace[6].regw, trace[6].pcs}, 4'b0111);

        // STR with three wait cycles in MEMWRITE
        run("str", 2'b01, 6'b011000, 4'd5, 0, 3, 7, -1);
        memw_n = 0; done_n = 0;
        for (int i = 0; i < trace_n; i++) begin
            memw_n += int'(trace[i].memw);
            done_n += int'(trace[i].done);
        end
        chk("str_memw_run", {memw_n[7:0], trace[3].memw, trace[6].memw}, {8'd4, 2'b11});
        chk("str_done_once", {done_n[7:0], trace[6].done}, {8'd1, 1'b1});

        // Branch
        run("branch", 2'b10, 6'b000000, 4'd0, 0, 0, 3, -1);
        chk("branch_outs", {trace[2].pcs, trace[2].asb, trace[2].alc}, 5'b10100);

        // Illegal op
        run("illegal", 2'b11, 6'b111111, 4'd15, 0, 0, 2, -1);
        bad_n = 0;
        for (int i = 0; i < trace_n; i++)
            bad_n += int'(trace[i].regw | trace[i].memw | trace[i].pcs);
        chk("illegal_no_writes", bad_n, 0);
        chk("illegal_pulse", {trace[1].ill, trace[1].done}, 2'b11);

        // STR abandoned by reset during its second MEMWRITE wait cycle
        run("str_abort", 2'b01, 6'b000000, 4'd6, 0, 3, 7, 4);
        chk("abort_memw_before", MemW, 1'b1);
        #1;
        MemReady = 1'b1;
        RESETn   = 1'b0;
        #1;
        chk("abort_memw_drops", MemW, 1'b0);
        chk("abort_reset_outs", dut_outs(), pc_step(1'b0));
        @(posedge CLK); #2;
        chk("abort_hold_reset", dut_outs(), pc_step(1'b0));
        @(negedge CLK);
        MemReady = 1'b0;
        RESETn   = 1'b1;
        @(posedge CLK); #1;
        run("post_reset_add", 2'b00, 6'b001001, 4'd7, 1, 0, 5, -1);
        run("post_reset_ldr", 2'b01, 6'b000001, 4'd8, 0, 0, 5, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_multicycle_ctrl
`default_nettype wire
